// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a bus master/interconnect and the SRAM responder.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM responder with programmable wait states and a
// two-cycle ERROR response for illegal size/alignment.
module ahb_sram_slave #(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** MEM_AW;
    localparam int unsigned AW    = MEM_AW + 2;
    localparam int unsigned CW    = 4;
    localparam int unsigned DW    = 32;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [AW-1:0]      r_addr;
    logic               r_write;
    logic [1:0]         r_size;
    logic               r_hreadyout;
    logic               r_hresp;
    logic [DW-1:0]      r_hrdata;
    logic [DW-1:0]      r_mem [DEPTH];

    logic               w_open;
    logic               w_accept;
    logic               w_legal;
    logic [3:0]         w_be;
    logic               w_commit;
    logic               w_rd_write;
    logic [MEM_AW-1:0]  w_rd_idx;
    logic [DW-1:0]      w_rd_word;
    logic               w_hreadyout_nxt;
    logic               w_hresp_nxt;
    logic [DW-1:0]      w_hrdata_nxt;
    logic               w_unused;

    // Address phases are only sampled while this slave drives hreadyout high.
    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_accept = w_open && bus.hsel && bus.hready && bus.htrans[1];

    always_comb begin
        w_legal = 1'b0;
        case (bus.hsize)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = ~bus.haddr[0];
            3'd2:    w_legal = (bus.haddr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_WAIT: w_state_nxt = (r_cnt == CW'(1)) ? ST_DATA : ST_WAIT;
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_addr[1:0];
            2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_commit = (r_state == ST_DATA) && r_write && !hreset;

    // Read source: the transfer entering its data phase at this edge.
    assign w_rd_write = w_accept ? bus.hwrite : r_write;
    assign w_rd_idx   = w_accept ? bus.haddr[AW-1:2] : r_addr[AW-1:2];

    // Forward lanes of a write committing on the same edge a read samples memory.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_commit && (r_addr[AW-1:2] == w_rd_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    w_rd_word[8*b +: 8] = bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    // Output values for the upcoming state, registered below.
    always_comb begin
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = 1'b0;
        w_hrdata_nxt    = '0;
        case (w_state_nxt)
            ST_WAIT: w_hreadyout_nxt = 1'b0;
            ST_ERR1: begin
                w_hreadyout_nxt = 1'b0;
                w_hresp_nxt     = 1'b1;
            end
            ST_ERR2: w_hresp_nxt = 1'b1;
            ST_DATA: begin
                if (!w_rd_write) begin
                    w_hrdata_nxt = w_rd_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= 2'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
            r_hrdata    <= w_hrdata_nxt;
            if (w_accept) begin
                r_addr  <= bus.haddr[AW-1:0];
                r_write <= bus.hwrite;
                r_size  <= bus.hsize[1:0];
            end
            if ((w_state_nxt == ST_WAIT) && (r_state != ST_WAIT)) begin
                r_cnt <= WAIT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Storage is not reset; writes land at the edge that ends the data phase.
    always_ff @(posedge hclk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_addr[AW-1:2]][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
    assign bus.hrdata    = r_hrdata;

    assign w_unused = ^{bus.haddr[31:AW], bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two responders (0 and 3 wait states) behind a select mux, driven by a pipelined
// master; a reference memory model feeds a scoreboard checked by a separate monitor.
module tb_ahb_sram_slave;
    localparam int unsigned MEM_AW = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int          WS0    = 0;
    localparam int          WS1    = 3;
    localparam logic [1:0]  HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NSEQ = 2'b10, HT_SEQ = 2'b11;
    localparam logic [2:0]  SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2;

    typedef struct {
        bit          err;
        int          lows;
        logic [31:0] rdata;
    } exp_t;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();

    ahb_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(WS0)) u_dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
    ahb_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(WS1)) u_dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1));

    logic        sel;
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [2:0]  m_hburst;
    logic [3:0]  m_hprot;
    logic [1:0]  m_htrans;
    logic        m_hmastlock;
    logic [31:0] m_hwdata;
    logic        bus_hready;
    logic        bus_hresp;
    logic [31:0] bus_hrdata;

    assign bus0.hsel = m_hsel & ~sel;
    assign bus1.hsel = m_hsel & sel;
    assign bus0.haddr = m_haddr;      assign bus1.haddr = m_haddr;
    assign bus0.hwrite = m_hwrite;    assign bus1.hwrite = m_hwrite;
    assign bus0.hsize = m_hsize;      assign bus1.hsize = m_hsize;
    assign bus0.hburst = m_hburst;    assign bus1.hburst = m_hburst;
    assign bus0.hprot = m_hprot;      assign bus1.hprot = m_hprot;
    assign bus0.htrans = m_htrans;    assign bus1.htrans = m_htrans;
    assign bus0.hmastlock = m_hmastlock; assign bus1.hmastlock = m_hmastlock;
    assign bus0.hwdata = m_hwdata;    assign bus1.hwdata = m_hwdata;
    assign bus_hready = sel ? bus1.hreadyout : bus0.hreadyout;
    assign bus_hresp  = sel ? bus1.hresp : bus0.hresp;
    assign bus_hrdata = sel ? bus1.hrdata : bus0.hrdata;
    assign bus0.hready = bus_hready;
    assign bus1.hready = bus_hready;

    logic [31:0] model [2][DEPTH];
    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b1;
    int          lows = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one address phase, wait for it to be taken, then predict its data phase.
    task automatic issue(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input bit selq);
        exp_t        e;
        int          n;
        int          s;
        int          idx;
        int          base;
        int          nb;
        logic [31:0] word;
        bit          legal;
        m_hsel      = selq;
        m_htrans    = trans;
        m_hwrite    = wr;
        m_haddr     = addr;
        m_hsize     = size;
        m_hburst    = 3'($urandom);
        m_hprot     = 4'($urandom);
        m_hmastlock = 1'($urandom);
        n = 0;
        while (!bus_hready && n < 64) begin
            @(posedge hclk); #1;
            n++;
        end
        if (!bus_hready) begin
            checks++;
            errors++;
            $display("FAIL hready_timeout: got 0 expected 1 (t=%0t)", $time);
        end
        @(posedge hclk); #1;
        s     = sel ? 1 : 0;
        idx   = int'((addr >> 2) % 32'(DEPTH));
        base  = int'(addr % 32'd4);
        legal = (size == SZ_B) || (size == SZ_H && base % 2 == 0) || (size == SZ_W && base == 0);
        e = '{err: 1'b0, lows: 0, rdata: 32'h0};
        if (selq && trans[1]) begin
            if (!legal) begin
                e.err  = 1'b1;
                e.lows = 1;
            end else begin
                e.lows = sel ? WS1 : WS0;
                if (wr) begin
                    nb   = 1 << size;
                    word = model[s][idx];
                    for (int k = 0; k < nb; k++) begin
                        word[8*(base+k) +: 8] = wdata[8*(base+k) +: 8];
                    end
                    model[s][idx] = word;
                end else begin
                    e.rdata = model[s][idx];
                end
            end
        end
        sb_q.push_back(e);
        m_hwdata = (trans[1] && wr) ? wdata : $urandom;
    endtask

    task automatic idle_settle();
        issue(HT_IDLE, 1'b0, 32'h0, SZ_W, 32'h0, 1'b1);
        @(posedge hclk); #1;
    endtask

    // Monitor: one scoreboard entry retires each time the selected slave ends a data phase.
    always @(negedge hclk) begin
        if (mon_en && sb_q.size() > 0) begin
            if (!bus_hready) begin
                lows++;
                chk("wait_hresp", 32'(bus_hresp), 32'(sb_q[0].err));
                chk("wait_hrdata", bus_hrdata, 32'h0);
            end else begin
                chk("wait_cycles", 32'(lows), 32'(sb_q[0].lows));
                chk("hresp", 32'(bus_hresp), 32'(sb_q[0].err));
                chk("hrdata", bus_hrdata, sb_q[0].rdata);
                void'(sb_q.pop_front());
                lows = 0;
            end
        end else begin
            lows = 0;
        end
    end

    initial begin
        int   r;
        logic wr;
        logic [1:0] tr;
        logic [2:0] sz;
        sel = 1'b0; m_hsel = 1'b0; m_haddr = '0; m_hwrite = 1'b0; m_hsize = SZ_W;
        m_hburst = '0; m_hprot = '0; m_htrans = HT_IDLE; m_hmastlock = 1'b0; m_hwdata = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hreadyout0", 32'(bus0.hreadyout), 32'h1);
        chk("rst_hresp0", 32'(bus0.hresp), 32'h0);
        chk("rst_hrdata0", bus0.hrdata, 32'h0);
        chk("rst_hreadyout1", 32'(bus1.hreadyout), 32'h1);
        chk("rst_hresp1", 32'(bus1.hresp), 32'h0);
        chk("rst_hrdata1", bus1.hrdata, 32'h0);
        hreset = 1'b0;

        // Fill both memories so every word has a known value.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int w = 0; w < int'(DEPTH); w++) begin
                issue(HT_NSEQ, 1'b1, 32'(w * 4), SZ_W, $urandom, 1'b1);
            end
            idle_settle();
        end

        sel = 1'b0;
        issue(HT_NSEQ, 1'b1, 32'h10, SZ_W, 32'hDEADBEEF, 1'b1);
        issue(HT_NSEQ, 1'b0, 32'h10, SZ_W, 32'h0, 1'b1);
        issue(HT_NSEQ, 1'b1, 32'h20, SZ_W, 32'h00000000, 1'b1);
        issue(HT_NSEQ, 1'b1, 32'h22, SZ_B, 32'h00AB0000, 1'b1);
        issue(HT_NSEQ, 1'b1, 32'h20, SZ_H, 32'h00001234, 1'b1);
        issue(HT_NSEQ, 1'b0, 32'h20, SZ_W, 32'h0, 1'b1);
        issue(HT_NSEQ, 1'b1, 32'h21, SZ_H, 32'hFFFFFFFF, 1'b1);
        issue(HT_NSEQ, 1'b0, 32'h20, SZ_W, 32'h0, 1'b1);
        idle_settle();

        sel = 1'b1;
        issue(HT_NSEQ, 1'b0, 32'h10, SZ_W, 32'h0, 1'b1);
        issue(HT_NSEQ, 1'b0, 32'h30, SZ_W, 32'h0, 1'b1);
        issue(HT_BUSY, 1'b0, 32'h34, SZ_W, 32'h0, 1'b1);
        issue(HT_SEQ,  1'b0, 32'h34, SZ_W, 32'h0, 1'b1);
        issue(HT_IDLE, 1'b0, 32'h38, SZ_W, 32'h0, 1'b1);
        issue(HT_SEQ,  1'b1, 32'h38, SZ_W, 32'h5A5A1234, 1'b1);
        issue(HT_SEQ,  1'b0, 32'h38, SZ_W, 32'h0, 1'b1);
        idle_settle();

        sel = 1'b0;
        issue(HT_NSEQ, 1'b1, (32'd4 << MEM_AW) + 32'h8, SZ_W, 32'hCAFEF00D, 1'b1);
        issue(HT_NSEQ, 1'b0, 32'h8, SZ_W, 32'h0, 1'b1);
        idle_settle();

        // Reset while a write sits in its wait states: nothing may be committed.
        sel = 1'b1;
        mon_en = 1'b0;
        m_hsel = 1'b1; m_htrans = HT_NSEQ; m_hwrite = 1'b1; m_haddr = 32'h8; m_hsize = SZ_W;
        @(posedge hclk); #1;
        chk("wait_before_reset", 32'(bus1.hreadyout), 32'h0);
        m_htrans = HT_IDLE;
        m_hwdata = 32'h13579BDF;
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        chk("reset_mid_hreadyout", 32'(bus1.hreadyout), 32'h1);
        chk("reset_mid_hresp", 32'(bus1.hresp), 32'h0);
        mon_en = 1'b1;
        issue(HT_NSEQ, 1'b0, 32'h8, SZ_W, 32'h0, 1'b1);
        idle_settle();

        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int i = 0; i < 250; i++) begin
                r  = int'($urandom % 8);
                tr = (r == 0) ? HT_IDLE : (r == 1) ? HT_BUSY : (r < 5) ? HT_NSEQ : HT_SEQ;
                wr = 1'($urandom);
                sz = ($urandom % 6 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom % 3);
                issue(tr, wr, $urandom, sz, $urandom, ($urandom % 10) != 0);
            end
            idle_settle();
        end

        repeat (3) @(posedge hclk);
        #1;
        chk("queue_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
